// File: rtl/fm_cfg_pkg.sv
// Field layout and default values of the FM transmitter configuration word,
// plus the state encoding shared by the SPI configuration loader.
package fm_cfg_pkg;
    localparam int N      = 18;
    localparam int L      = 12;
    localparam int D      = 5;
    localparam int DITH_W = 3;
    localparam int FLAG_W = 3;
    localparam int CFG_DW = N + L + D + DITH_W + FLAG_W + 1;

    // Bit positions inside the word, counted from the LSB.
    localparam int SPI_OVERRIDE_POS = 0;
    localparam int FLAG0_POS        = 1;
    localparam int FLAG1_POS        = 2;
    localparam int FLAG2_POS        = 3;
    localparam int DITH_FACT_POS    = 4;
    localparam int DAC_ENA_POS      = DITH_FACT_POS + DITH_W;
    localparam int DF_INC_POS       = DAC_ENA_POS + D;
    localparam int ACC_INC_POS      = DF_INC_POS + L;

    localparam logic [N-1:0]      ACC_INC_DEF   = 18'h0a3d7;
    localparam logic [L-1:0]      DF_INC_DEF    = 12'h040;
    localparam logic [D-1:0]      DAC_ENA_DEF   = 5'h1f;
    localparam logic [DITH_W-1:0] DITH_FACT_DEF = 3'd2;

    function automatic logic [CFG_DW-1:0] cfg_pack(
        input logic [N-1:0]      acc_inc,
        input logic [L-1:0]      df_inc,
        input logic [D-1:0]      dac_ena,
        input logic [DITH_W-1:0] dith_fact,
        input logic [FLAG_W-1:0] flags,
        input logic              spi_override
    );
        return {acc_inc, df_inc, dac_ena, dith_fact, flags, spi_override};
    endfunction

    localparam logic [CFG_DW-1:0] CFG_DEF =
        cfg_pack(ACC_INC_DEF, DF_INC_DEF, DAC_ENA_DEF, DITH_FACT_DEF, 3'b000, 1'b0);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_HIGH = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
endpackage

// File: rtl/spi_clk_phase_timer.sv
// Half-period counter: phase_end strobes on the last of every CLK_DIV cycles.
// clear holds the count at zero so the first phase after it is full length.
module spi_clk_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);
    localparam int              HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0]   LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] hc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
        end else if (clear || hc == LAST) begin
            hc <= '0;
        end else begin
            hc <= hc + HW'(1);
        end
    end

    assign phase_end = (hc == LAST);
endmodule

// File: rtl/spi_config_master.sv
// SPI mode-0 initiator that shifts a configuration word MSB-first and captures MISO.
// Optional macro SPI_CONFIG_VERIFY_EN: every request runs twice and verify_err flags a bad read-back.
module spi_config_master
    import fm_cfg_pkg::*;
#(
    parameter int DW      = CFG_DW,
    parameter int CLK_DIV = 4,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] tx_word,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_word,
    output logic          spi_clk,
    output logic          spi_csn,
    output logic          spi_mosi,
    input  logic          spi_miso
`ifdef SPI_CONFIG_VERIFY_EN
    ,
    output logic          verify_err
`endif
);
    logic [2:0]    state;
    logic [DW-2:0] tx_sh;
    logic [DW-1:0] rx_sh;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_nxt;
    logic          phase_end;
    logic          timer_clear;

`ifdef SPI_CONFIG_VERIFY_EN
    logic [DW-1:0] tx_keep;
    logic [DW-1:0] rx_first;
    logic          second_pass;
`endif

    assign bit_cnt_nxt = bit_cnt + CW'(1);
    assign timer_clear = (state == ST_IDLE);

    spi_clk_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .phase_end (phase_end)
    );

    // Handshake: start is a one-shot request taken only in IDLE (busy=0); it is
    // dropped, not queued, while busy. done pulses once with rx_word valid and busy low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_word  <= '0;
            spi_clk  <= 1'b0;
            spi_csn  <= 1'b1;
            spi_mosi <= 1'b0;
`ifdef SPI_CONFIG_VERIFY_EN
            tx_keep     <= '0;
            rx_first    <= '0;
            second_pass <= 1'b0;
            verify_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sh    <= tx_word[DW-2:0];
                        bit_cnt  <= '0;
                        spi_csn  <= 1'b0;
                        spi_mosi <= tx_word[DW-1];
                        busy     <= 1'b1;
                        state    <= ST_LOW;
`ifdef SPI_CONFIG_VERIFY_EN
                        tx_keep     <= tx_word;
                        second_pass <= 1'b0;
`endif
                    end
                end
                ST_LOW: begin
                    // The slave shifts on this same SCK rise, so MISO still shows its old bit.
                    if (phase_end) begin
                        spi_clk <= 1'b1;
                        rx_sh   <= {rx_sh[DW-2:0], spi_miso};
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        spi_clk <= 1'b0;
                        bit_cnt <= bit_cnt_nxt;
                        if (bit_cnt_nxt < CW'(DW)) begin
                            spi_mosi <= tx_sh[DW-2];
                            tx_sh    <= {tx_sh[DW-3:0], 1'b0};
                            state    <= ST_LOW;
                        end else begin
                            spi_mosi <= 1'b0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        spi_csn <= 1'b1;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (phase_end) begin
`ifdef SPI_CONFIG_VERIFY_EN
                        if (!second_pass) begin
                            second_pass <= 1'b1;
                            rx_first    <= rx_sh;
                            tx_sh       <= tx_keep[DW-2:0];
                            bit_cnt     <= '0;
                            spi_csn     <= 1'b0;
                            spi_mosi    <= tx_keep[DW-1];
                            state       <= ST_LOW;
                        end else begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            rx_word    <= rx_first;
                            verify_err <= (rx_sh != tx_keep);
                            state      <= ST_IDLE;
                        end
`else
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rx_word <= rx_sh;
                        state   <= ST_IDLE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_config_master.sv
// Bench for spi_config_master: CLK_DIV=2 and CLK_DIV=1 instances, each with a slave shift register.
// Also covers the SPI_CONFIG_VERIFY_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_spi_config_master;
    import fm_cfg_pkg::*;

    localparam int DW = CFG_DW;
    localparam int CW = 6;
`ifdef SPI_CONFIG_VERIFY_EN
    localparam int FRAMES = 2;
`else
    localparam int FRAMES = 1;
`endif
    localparam logic [DW-1:0] LOW5   = DW'(5'h1f);
    localparam logic [DW-1:0] B5_CLR = ~(DW'(1) << 5);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          slv_init;
    logic          force_b5;
    logic          start0, start1;
    logic [DW-1:0] tx0, tx1;
    logic          busy0, busy1, done0, done1;
    logic [DW-1:0] rx0, rx1;
    logic          sck0, sck1, csn0, csn1, mosi0, mosi1;
    logic [DW-1:0] slv0, slv1;
`ifdef SPI_CONFIG_VERIFY_EN
    logic          verr0, verr1;
`endif

    spi_config_master #(.DW(DW), .CLK_DIV(2), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .tx_word(tx0),
        .busy(busy0), .done(done0), .rx_word(rx0),
        .spi_clk(sck0), .spi_csn(csn0), .spi_mosi(mosi0), .spi_miso(slv0[DW-1])
`ifdef SPI_CONFIG_VERIFY_EN
        , .verify_err(verr0)
`endif
    );

    spi_config_master #(.DW(DW), .CLK_DIV(1), .CW(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_word(tx1),
        .busy(busy1), .done(done1), .rx_word(rx1),
        .spi_clk(sck1), .spi_csn(csn1), .spi_mosi(mosi1), .spi_miso(slv1[DW-1])
`ifdef SPI_CONFIG_VERIFY_EN
        , .verify_err(verr1)
`endif
    );

    // Slave models: shift on SCK rise while selected; slave 0 can have cell 5 stuck at 0.
    always @(posedge sck0 or posedge slv_init) begin
        if (slv_init)    slv0 <= CFG_DEF;
        else if (!csn0)  slv0 <= force_b5 ? ({slv0[DW-2:0], mosi0} & B5_CLR) : {slv0[DW-2:0], mosi0};
    end

    always @(posedge sck1 or posedge slv_init) begin
        if (slv_init)    slv1 <= CFG_DEF;
        else if (!csn1)  slv1 <= {slv1[DW-2:0], mosi1};
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] slv_model[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom, $urandom});
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_busy", busy0, 1'b0);
            check_eq("idle_csn", csn0, 1'b1);
        end
    endtask

    // Called at a negedge: requests a frame and follows it until done or max_cyc cycles.
    task automatic run_frame(input int sel, input logic [DW-1:0] tx, input bit noise,
                             input int max_cyc, input bit expect_done);
        logic [DW-1:0] sent, exp_rx, exp_slv, got_rx, got_slv;
        logic          prev_sck, c_sck, c_csn, c_mosi, c_done, c_busy;
        int            lat, rises, csn_low, div, exp_lat;
        div      = (sel != 0) ? 1 : 2;
        exp_lat  = FRAMES * (2 * DW + 2) * div;
        sent     = '0;
        lat      = -1;
        rises    = 0;
        csn_low  = 0;
        prev_sck = 1'b0;
        exp_q.push_back(slv_model[sel]);
        if (sel != 0) begin start1 = 1'b1; tx1 = tx; end
        else          begin start0 = 1'b1; tx0 = tx; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        for (int cyc = 0; cyc <= max_cyc; cyc++) begin
            c_sck  = (sel != 0) ? sck1  : sck0;
            c_csn  = (sel != 0) ? csn1  : csn0;
            c_mosi = (sel != 0) ? mosi1 : mosi0;
            c_done = (sel != 0) ? done1 : done0;
            c_busy = (sel != 0) ? busy1 : busy0;
            if (cyc == 0) begin
                check_eq("t0_csn", c_csn, 1'b0);
                check_eq("t0_busy", c_busy, 1'b1);
                check_eq("t0_mosi", c_mosi, tx[DW-1]);
                check_eq("t0_done_low", c_done, 1'b0);
            end
            if (c_sck && !prev_sck) begin
                rises++;
                sent = {sent[DW-2:0], c_mosi};
            end
            prev_sck = c_sck;
            if (!c_csn) csn_low++;
            if (c_done) begin
                lat = cyc;
                break;
            end
            if (noise && sel == 0 && cyc + 4 < exp_lat) begin
                start0 = 1'($urandom_range(0, 1));
                tx0    = rand_word();
            end else begin
                start0 = 1'b0;
            end
            if (cyc < max_cyc) @(negedge clk);
        end
        start0 = 1'b0;
        exp_rx = exp_q.pop_front();
        if (expect_done) begin
            // A stuck cell 5 zeroes old bits 4:0 on their way to MISO and every bit that passes it.
            if (sel == 0 && force_b5) exp_rx = exp_rx & ~LOW5;
            exp_slv = (sel == 0 && force_b5) ? (tx & LOW5) : tx;
            got_rx  = (sel != 0) ? rx1 : rx0;
            got_slv = (sel != 0) ? slv1 : slv0;
            check_eq("done_latency", lat, exp_lat);
            check_eq("sck_rises", rises, FRAMES * DW);
            check_eq("mosi_word", sent, tx);
            check_eq("csn_low_cycles", csn_low, FRAMES * (2 * DW + 1) * div);
            check_eq("rx_word", got_rx, exp_rx);
            check_eq("slave_reg", got_slv, exp_slv);
            check_eq("done_busy", (sel != 0) ? busy1 : busy0, 1'b0);
            check_eq("done_csn", (sel != 0) ? csn1 : csn0, 1'b1);
            check_eq("done_sck", (sel != 0) ? sck1 : sck0, 1'b0);
`ifdef SPI_CONFIG_VERIFY_EN
            check_eq("verify_err", (sel != 0) ? verr1 : verr0, exp_slv != tx);
`endif
            slv_model[sel] = exp_slv;
        end else begin
            check_eq("no_done_yet", lat, -1);
            for (int i = 0; i < rises; i++)
                slv_model[sel] = {slv_model[sel][DW-2:0], tx[DW-1-i]};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        start0 = 1'b0; start1 = 1'b0; tx0 = '0; tx1 = '0;
        force_b5 = 1'b0; rst_n = 1'b0; slv_init = 1'b1;
        slv_model[0] = CFG_DEF;
        slv_model[1] = CFG_DEF;
        repeat (3) @(negedge clk);
        slv_init = 1'b0;
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_done", done0, 1'b0);
        check_eq("rst_rx", rx0, '0);
        check_eq("rst_sck", sck0, 1'b0);
        check_eq("rst_csn", csn0, 1'b1);
        check_eq("rst_mosi", mosi0, 1'b0);
        check_eq("rst_csn1", csn1, 1'b1);
        check_eq("rst_sck1", sck1, 1'b0);
`ifdef SPI_CONFIG_VERIFY_EN
        check_eq("rst_verr", verr0, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 42'h155_5555_5555, 1'b0, 2000, 1'b1);
        idle_cycles(3);
        run_frame(0, 42'h3ff_ffff_ffff, 1'b0, 2000, 1'b1);
        run_frame(0, 42'h000_0000_0001, 1'b0, 2000, 1'b1);
        idle_cycles(2);

        // Requests and word changes while busy must not touch the running frame.
        run_frame(0, rand_word(), 1'b1, 2000, 1'b1);
        idle_cycles(4);

        for (int i = 0; i < 6; i++) begin
            run_frame(0, rand_word(), 1'($urandom_range(0, 1)), 2000, 1'b1);
            if ($urandom_range(0, 1) != 0) idle_cycles($urandom_range(1, 5));
        end

        // Reset in the middle of a frame.
        w = rand_word();
        run_frame(0, w, 1'b0, 20, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_csn", csn0, 1'b1);
        check_eq("mid_rst_sck", sck0, 1'b0);
        check_eq("mid_rst_busy", busy0, 1'b0);
        check_eq("mid_rst_rx", rx0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_no_done", done0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, rand_word(), 1'b0, 2000, 1'b1);
        idle_cycles(2);

        run_frame(1, 42'h2aa_aaaa_aaaa, 1'b0, 1000, 1'b1);
        @(negedge clk);
        run_frame(1, rand_word(), 1'b0, 1000, 1'b1);

`ifdef SPI_CONFIG_VERIFY_EN
        @(negedge clk);
        force_b5 = 1'b1;
        run_frame(0, rand_word() | (DW'(1) << 5), 1'b0, 2000, 1'b1);
        force_b5 = 1'b0;
        idle_cycles(2);
        run_frame(0, rand_word(), 1'b0, 2000, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
